// File: rtl/acc_drain_quant_pkg.sv
// Shared definitions for the accumulator drain stage: FSM encoding,
// default widths and the round/shift/ReLU/saturate helper used by
// quantizing stages.
`timescale 1ns/1ps
package acc_drain_quant_pkg;

   localparam int ACC_W_DEF = 40;
   localparam int OUT_W_DEF = 8;
   localparam int CNT_W_DEF = 16;
   localparam int DEPTH_DEF = 4;

   // Working width of the quantizer helper. Callers sign-extend their
   // accumulator into it. The add of the rounding constant cannot overflow
   // ACC_W+1 bits, so a wider working width gives the same result.
   // ACC_W must stay below QW.
   localparam int QW = 64;

   localparam logic signed [QW-1:0] Q_ONE  = 64'sd1;
   localparam logic signed [QW-1:0] Q_ZERO = 64'sd0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COUNT   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_FINISH  = 2'd3
   } drain_state_e;

   // Round half up, arithmetic shift right, optional ReLU, then saturate to
   // a signed out_w-bit range. clip reports that saturation changed the value.
   function automatic logic signed [QW-1:0] quant_round_sat(
      input  logic signed [QW-1:0] v,
      input  logic        [5:0]    sh,
      input  logic                 relu,
      input  int                   out_w,
      output logic                 clip
   );
      logic signed [QW-1:0] r;
      logic signed [QW-1:0] hi;
      logic signed [QW-1:0] lo;
      logic        [5:0]    sh_m1;
      sh_m1 = sh - 6'd1;
      if (sh != 6'd0) begin
         r = v + (Q_ONE <<< sh_m1);
      end else begin
         r = v;
      end
      r = r >>> sh;
      if (relu && r[QW-1]) begin
         r = Q_ZERO;
      end else begin
         r = r;
      end
      hi = (Q_ONE <<< (out_w - 1)) - Q_ONE;
      lo = -hi - Q_ONE;
      if (r > hi) begin
         r    = hi;
         clip = 1'b1;
      end else if (r < lo) begin
         r    = lo;
         clip = 1'b1;
      end else begin
         clip = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/acc_drain_quant_drain_fifo.sv
// Small synchronous output FIFO for quantized results. The head entry comes
// straight from the storage registers. A push is accepted only while
// entries remain free; nothing bypasses storage. A pop on empty is ignored.
`timescale 1ns/1ps
module drain_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(1'b0);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign push_ok_s = push && (count_r != CNT_FULL);
   assign pop_ok_s  = pop && (count_r != CNT_ZERO);
   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == CNT_ZERO);
   assign pop_data  = mem_r[rd_ptr_r];

   // Storage array: written at the tail on an accepted push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= CNT_ZERO;
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10: begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
               count_r  <= count_r + CNT_ONE;
            end
            2'b01: begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
               count_r  <= count_r - CNT_ONE;
            end
            2'b11: begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            default: begin
               wr_ptr_r <= wr_ptr_r;
               rd_ptr_r <= rd_ptr_r;
               count_r  <= count_r;
            end
         endcase
      end
   end

endmodule

// File: rtl/acc_drain_quant.sv
// Drain stage behind the signed partial-sum accumulator. It counts the
// accumulation beats for each output and captures the finished sum one cycle
// after the last beat. It quantizes that sum to OUT_W bits and queues the
// result for writeback. It also drives the accumulator clear and stalls
// upstream while the output queue is full.
`timescale 1ns/1ps
module acc_drain_quant
   import acc_drain_quant_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] acc_len,
   input  logic [CNT_W-1:0] num_out,
   input  logic [5:0]       shift,
   input  logic             relu_en,
   input  logic [ACC_W-1:0] acc_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             acc_clr,
   output logic             busy,
   output logic             done,
   output logic             sat_flag,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   drain_state_e         state_r;
   drain_state_e         state_nxt_s;
   logic [CNT_W-1:0]     len_r;
   logic [CNT_W-1:0]     num_r;
   logic [5:0]           shift_r;
   logic                 relu_r;
   logic [CNT_W-1:0]     beat_cnt_r;
   logic [CNT_W-1:0]     out_cnt_r;
   logic [CNT_W-1:0]     out_cnt_inc_s;
   logic                 in_ready_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 sat_flag_r;
   logic                 start_ok_s;
   logic                 push_s;
   logic                 pop_s;
   logic                 full_s;
   logic                 empty_s;
   logic                 last_beat_s;
   logic                 last_out_s;
   logic                 clip_s;
   logic signed [QW-1:0] acc_ext_s;
   logic signed [QW-1:0] q_full_s;
   logic [OUT_W-1:0]     q_data_s;
   logic [OUT_W-1:0]     fifo_head_s;
   logic                 unused_q_s;

   assign out_cnt_inc_s = out_cnt_r + CNT_ONE;
   assign last_beat_s   = (beat_cnt_r == (len_r - CNT_ONE));
   assign last_out_s    = (out_cnt_inc_s == num_r);
   assign acc_ext_s     = {{(QW-ACC_W){acc_in[ACC_W-1]}}, acc_in};
   assign q_data_s      = q_full_s[OUT_W-1:0];
   assign unused_q_s    = ^q_full_s[QW-1:OUT_W];

   // Quantize the captured sum with the parameters latched at job start.
   always_comb begin
      clip_s   = 1'b0;
      q_full_s = quant_round_sat(acc_ext_s, shift_r, relu_r, OUT_W, clip_s);
   end

   // Next-state logic. A push happens only in CAPTURE and only when the FIFO has space.
   always_comb begin
      state_nxt_s = state_r;
      start_ok_s  = 1'b0;
      push_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               start_ok_s = 1'b1;
               if (num_out != CNT_ZERO) begin
                  state_nxt_s = ST_COUNT;
               end else begin
                  state_nxt_s = ST_FINISH;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_COUNT: begin
            if (in_valid && last_beat_s) begin
               state_nxt_s = ST_CAPTURE;
            end else begin
               state_nxt_s = ST_COUNT;
            end
         end
         ST_CAPTURE: begin
            if (!full_s) begin
               push_s = 1'b1;
               if (last_out_s) begin
                  state_nxt_s = ST_FINISH;
               end else begin
                  state_nxt_s = ST_COUNT;
               end
            end else begin
               state_nxt_s = ST_CAPTURE;
            end
         end
         ST_FINISH: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Job parameters are latched on an accepted start. A length of zero counts as one beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_r   <= CNT_ONE;
         num_r   <= CNT_ZERO;
         shift_r <= 6'd0;
         relu_r  <= 1'b0;
      end else if (start_ok_s) begin
         len_r   <= (acc_len == CNT_ZERO) ? CNT_ONE : acc_len;
         num_r   <= num_out;
         shift_r <= shift;
         relu_r  <= relu_en;
      end else begin
         len_r   <= len_r;
         num_r   <= num_r;
         shift_r <= shift_r;
         relu_r  <= relu_r;
      end
   end

   // Beat counter: counts accepted terms and restarts after each capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         beat_cnt_r <= CNT_ZERO;
      end else if (start_ok_s || push_s) begin
         beat_cnt_r <= CNT_ZERO;
      end else if ((state_r == ST_COUNT) && in_valid) begin
         beat_cnt_r <= beat_cnt_r + CNT_ONE;
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

   // Output counter: counts results pushed in the current job.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_cnt_r <= CNT_ZERO;
      end else if (start_ok_s) begin
         out_cnt_r <= CNT_ZERO;
      end else if (push_s) begin
         out_cnt_r <= out_cnt_inc_s;
      end else begin
         out_cnt_r <= out_cnt_r;
      end
   end

   // Sticky saturation flag: cleared by an accepted start, set by any clipped push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_flag_r <= 1'b0;
      end else if (start_ok_s) begin
         sat_flag_r <= 1'b0;
      end else if (push_s && clip_s) begin
         sat_flag_r <= 1'b1;
      end else begin
         sat_flag_r <= sat_flag_r;
      end
   end

   // Status outputs registered from the next state, so they line up with state_r.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         in_ready_r <= (state_nxt_s == ST_COUNT);
         busy_r     <= (state_nxt_s != ST_IDLE);
         done_r     <= (state_nxt_s == ST_FINISH);
      end
   end

   drain_fifo #(
      .DEPTH (DEPTH),
      .W     (OUT_W)
   ) u_drain_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (q_data_s),
      .pop       (pop_s),
      .pop_data  (fifo_head_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   assign pop_s     = out_ready && !empty_s;
   assign out_valid = !empty_s;
   assign out_data  = fifo_head_s;
   // The clear pulse is the push itself. It depends only on state_r and the FIFO count.
   assign acc_clr   = push_s;
   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign sat_flag  = sat_flag_r;

endmodule

// File: tb/tb_acc_drain_quant.sv
// Directed self-checking bench for acc_drain_quant. The bench acts as the
// upstream feeder and models the accumulator, so acc_in follows the beats
// it drives.
`timescale 1ns/1ps
module tb_acc_drain_quant;

   localparam int ACC_W = 40;
   localparam int OUT_W = 8;
   localparam int CNT_W = 16;
   localparam int DEPTH = 4;

   logic                    clk;
   logic                    reset;
   logic                    start;
   logic [CNT_W-1:0]        acc_len;
   logic [CNT_W-1:0]        num_out;
   logic [5:0]              shift;
   logic                    relu_en;
   logic signed [ACC_W-1:0] acc_in;
   logic                    in_valid;
   logic                    in_ready;
   logic                    acc_clr;
   logic                    busy;
   logic                    done;
   logic                    sat_flag;
   logic [OUT_W-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] term;

   int n_tests = 0;
   int n_fail  = 0;
   int s_len, s_base, s_fed, s_got, s_dones;

   acc_drain_quant #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .CNT_W (CNT_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .acc_len   (acc_len),
      .num_out   (num_out),
      .shift     (shift),
      .relu_en   (relu_en),
      .acc_in    (acc_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .acc_clr   (acc_clr),
      .busy      (busy),
      .done      (done),
      .sat_flag  (sat_flag),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accumulator model: clears on acc_clr and adds a term only on an accepted beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      acc_in <= '0;
      else if (acc_clr)               acc_in <= '0;
      else if (in_valid && in_ready)  acc_in <= acc_in + term;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input int len, input int num, input int sh, input logic relu);
      acc_len = CNT_W'(len);
      num_out = CNT_W'(num);
      shift   = 6'(sh);
      relu_en = relu;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Single-term, single-output job; checks the quantized value and the sticky flag.
   task automatic one_out(input string tag, input longint sum, input int sh, input logic relu,
                          input logic [7:0] exp, input logic exp_sat);
      do_start(1, 1, sh, relu);
      in_valid = 1'b1;
      term     = ACC_W'(sum);
      tick();
      in_valid = 1'b0;
      term     = '0;
      tick();
      check({tag, "_data"}, 32'(out_data), 32'(exp));
      check({tag, "_sat"}, 32'(sat_flag), 32'(exp_sat));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   // Streaming feeder and consumer. Output k has the sum s_base+k,
   // formed by one nonzero first beat followed by zero beats.
   task automatic stream_cycles(input string tag, input int ncyc, input int want);
      for (int c = 0; c < ncyc; c++) begin
         if (want > 0 && s_got >= want) break;
         if (done) s_dones++;
         if (out_valid && out_ready) begin
            check(tag, 32'(out_data), 32'(s_base + s_got));
            s_got++;
         end
         if (in_ready) begin
            in_valid = 1'b1;
            term     = (s_fed % s_len == 0) ? ACC_W'(s_base + s_fed / s_len) : '0;
            s_fed++;
         end else begin
            in_valid = 1'b0;
            term     = '0;
         end
         tick();
      end
      in_valid = 1'b0;
      term     = '0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; acc_len = '0; num_out = '0; shift = '0;
      relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; term = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_acc_clr",   32'(acc_clr),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_sat",       32'(sat_flag),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);

      // 1: four beats summing to 100, with a gap in the middle.
      do_start(4, 1, 0, 1'b0);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; term = 40'sd10; tick();
      term = 40'sd20; tick();
      in_valid = 1'b0; term = '0; tick();
      check("t1_hold_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; term = 40'sd30; tick();
      check("t1_clr_count", 32'(acc_clr), 32'd0);
      term = 40'sd40; tick();
      in_valid = 1'b0; term = '0;
      check("t1_clr_capture", 32'(acc_clr), 32'd1);
      check("t1_in_ready_capture", 32'(in_ready), 32'd0);
      check("t1_valid_capture", 32'(out_valid), 32'd0);
      tick();
      check("t1_clr_after", 32'(acc_clr), 32'd0);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_data", 32'(out_data), 32'd100);
      check("t1_done", 32'(done), 32'd1);
      check("t1_sat", 32'(sat_flag), 32'd0);
      tick();
      check("t1_done_pulse", 32'(done), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      check("t1_popped", 32'(out_valid), 32'd0);

      // 2: saturation and ReLU.
      one_out("t2_pos_sat", 1002, 2, 1'b0, 8'd127, 1'b1);
      one_out("t2_neg_sat", -300, 1, 1'b0, 8'h80, 1'b1);
      one_out("t2_relu",    -300, 1, 1'b1, 8'd0,  1'b0);

      // 3: rounding.
      one_out("t3_rnd_pos", 5,    1, 1'b0, 8'd3,   1'b0);
      one_out("t3_rnd_neg", -5,   1, 1'b0, 8'hFE,  1'b0);
      one_out("t3_rnd_big", 1000, 3, 1'b0, 8'd125, 1'b0);

      // 4: back-pressure with a full FIFO, then drain in order.
      s_len = 2; s_base = 1; s_fed = 0; s_got = 0; s_dones = 0;
      out_ready = 1'b0;
      do_start(2, 6, 0, 1'b0);
      stream_cycles("t4_data", 40, 0);
      check("t4_fed_beats", 32'(s_fed), 32'd10);
      check("t4_stall_in_ready", 32'(in_ready), 32'd0);
      check("t4_stall_acc_clr", 32'(acc_clr), 32'd0);
      check("t4_stall_busy", 32'(busy), 32'd1);
      check("t4_stall_head", 32'(out_data), 32'd1);
      check("t4_no_done_yet", 32'(s_dones), 32'd0);
      out_ready = 1'b1;
      stream_cycles("t4_data", 80, 6);
      check("t4_got", 32'(s_got), 32'd6);
      for (int i = 0; i < 3; i++) begin
         if (done) s_dones++;
         tick();
      end
      out_ready = 1'b0;
      check("t4_done_once", 32'(s_dones), 32'd1);
      check("t4_idle", 32'(busy), 32'd0);
      check("t4_empty", 32'(out_valid), 32'd0);

      // 5: reset during COUNT with two saturated entries queued.
      do_start(1, 4, 0, 1'b0);
      in_valid = 1'b1; term = 40'sd1000; tick();
      in_valid = 1'b0; term = '0; tick();
      in_valid = 1'b1; term = 40'sd1000; tick();
      in_valid = 1'b0; term = '0; tick();
      check("t5_pre_valid", 32'(out_valid), 32'd1);
      check("t5_pre_sat", 32'(sat_flag), 32'd1);
      check("t5_pre_in_ready", 32'(in_ready), 32'd1);
      reset = 1'b1;
      #1;
      check("t5_rst_valid", 32'(out_valid), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_in_ready", 32'(in_ready), 32'd0);
      check("t5_rst_sat", 32'(sat_flag), 32'd0);
      check("t5_rst_data", 32'(out_data), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      one_out("t5_after", 5, 1, 1'b0, 8'd3, 1'b0);
      check("t5_after_empty", 32'(out_valid), 32'd0);

      // 6a: acc_len=0 acts as one beat per output.
      s_len = 1; s_base = 7; s_fed = 0; s_got = 0; s_dones = 0;
      out_ready = 1'b1;
      do_start(0, 3, 0, 1'b0);
      stream_cycles("t6_len0_data", 60, 3);
      check("t6_len0_got", 32'(s_got), 32'd3);
      tick(); tick();
      out_ready = 1'b0;
      check("t6_len0_done", 32'(s_dones), 32'd1);
      check("t6_len0_idle", 32'(busy), 32'd0);

      // 6b: num_out=0 finishes at once without a push.
      do_start(3, 0, 0, 1'b0);
      check("t6_num0_done", 32'(done), 32'd1);
      check("t6_num0_busy", 32'(busy), 32'd1);
      tick();
      check("t6_num0_done_pulse", 32'(done), 32'd0);
      check("t6_num0_no_push", 32'(out_valid), 32'd0);

      // 6c: start while busy is ignored; the job keeps its one-beat length.
      do_start(1, 1, 0, 1'b0);
      do_start(5, 0, 0, 1'b0);
      check("t6_busy_start_in_ready", 32'(in_ready), 32'd1);
      check("t6_busy_start_done", 32'(done), 32'd0);
      in_valid = 1'b1; term = 40'sd42; tick();
      in_valid = 1'b0; term = '0;
      check("t6_busy_start_capture", 32'(acc_clr), 32'd1);
      tick();
      check("t6_busy_start_data", 32'(out_data), 32'd42);
      check("t6_busy_start_fin", 32'(done), 32'd1);
      out_ready = 1'b1; tick(); out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_drain_quant.md
Name: acc_drain_quant

Overview:
Downstream drain stage for the signed partial-sum accumulator. It counts the accumulation beats for each output and captures the finished sum one cycle after the last beat. It then rounds, shifts, applies optional ReLU and saturates the sum to OUT_W bits, and pushes it into a small output FIFO. The FIFO has a valid/ready interface to the writeback path. It also generates the accumulator clear pulse and stalls the upstream feeder when the FIFO is full.

Parameters:
ACC_W, 40, accumulator width (signed)
OUT_W, 8, quantized output width (signed)
CNT_W, 16, width of beat and output counters
DEPTH, 4, output FIFO depth (power of 2, >=2)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; latches acc_len, num_out, shift, relu_en; ignored while busy
acc_len  input  CNT_W  accumulation beats per output (0 treated as 1)
num_out  input  CNT_W  outputs to produce per job
shift  input  6  arithmetic right-shift amount (0..ACC_W-1)
relu_en  input  1  clamp negatives to 0 before saturation
acc_in  input  ACC_W  accumulator registered sum
in_valid  input  1  upstream drives a valid term into the accumulator this cycle
in_ready  output  1  high only in COUNT; upstream must drive a zero term when low
acc_clr  output  1  active-high clear; top level inverts it into the accumulator's active-low sync clear
busy  output  1  job in progress
done  output  1  one-cycle pulse when the last output is pushed into the FIFO
sat_flag  output  1  sticky; set on any saturation, cleared on accepted start
out_data  output  OUT_W  FIFO head
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts when out_valid & out_ready

Behaviour:
- Reset (async, any state): FSM->IDLE; all counters 0; FIFO empty.
  Outputs: in_ready=0, acc_clr=0, busy=0, done=0, sat_flag=0, out_valid=0, out_data=0.
- FSM states: IDLE, COUNT, CAPTURE, FINISH.
- IDLE:
  - start with num_out!=0 -> COUNT, beat_cnt=0, out_cnt=0, sat_flag cleared.
  - start with num_out==0 -> FINISH.
- COUNT:
  - in_ready=1; each cycle with in_valid increments beat_cnt.
  - The beat with beat_cnt==len-1 -> CAPTURE.
  - in_valid low holds state.
- CAPTURE:
  - in_ready=0; acc_in now holds the full sum, because the accumulator registers one cycle after the last beat.
  - If FIFO not full: push q(acc_in), assert acc_clr for this cycle, out_cnt++, beat_cnt=0.
    - out_cnt then == num_out -> FINISH; else -> COUNT.
  - If FIFO full: stay in CAPTURE with acc_clr=0.
    - The accumulator holds its value because upstream feeds zero.
- FINISH: done=1 for one cycle -> IDLE.
- busy=1 in COUNT, CAPTURE and FINISH.
- Quantization (combinational, computed in ACC_W+1 bits):
  - r = acc_in + (shift>0 ? 1<<(shift-1) : 0); then arithmetic shift: r>>>shift.
  - If relu_en and r<0: r=0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any clip sets sat_flag.
- Latency: last valid beat in cycle t -> capture/acc_clr in t+1 -> out_valid in t+2 if the FIFO was empty.
- FIFO:
  - Registered head; push only when count<DEPTH, no bypass.
  - Simultaneous push and pop when non-empty: count unchanged, order preserved.
  - Pop on empty is ignored.
- Wrap-around: beat_cnt and out_cnt compare against latched values and never wrap within a job.
- Reset mid-job discards FIFO contents and the partial sum bookkeeping; the accumulator is cleared by its own reset.

Decomposition:
- Shared package: FSM state encoding, default widths ACC_W/OUT_W/CNT_W, and a saturate/round helper function reused by other quantizing stages.
- One sub-module: drain_fifo, a synchronous DEPTH x OUT_W FIFO with full/empty and async active-high reset.

Test Plan:
1. acc_len=4, num_out=1, shift=0, terms 10,20,30,40 -> out_data=100; acc_clr high exactly one cycle (t+1); out_valid at t+2; done pulse; sat_flag=0.
2. Sum 1002, shift=2 -> 251 saturates to 127, sat_flag=1. Sum -300, shift=1 -> -128, sat_flag=1. Same sum with relu_en=1 -> 0.
3. Rounding: sum 5, shift=1 -> 3. Sum -5, shift=1 -> -2. Sum 1000, shift=3 -> 125.
4. DEPTH=4, num_out=6, acc_len=2, out_ready=0 -> 4 entries stored; FSM held in CAPTURE with in_ready=0 and acc_clr=0. Raise out_ready -> all 6 outputs drained in order, done once.
5. Assert reset during COUNT with 2 entries in the FIFO -> same cycle: out_valid=0, busy=0, in_ready=0, sat_flag=0; subsequent start runs cleanly.
6. acc_len=0 -> behaves as 1 (each term becomes one output). num_out=0 -> done pulse one cycle after start, no FIFO push. start while busy -> ignored.
